// File: rtl/fa4_display_scanner.sv
// Multiplexed seven-segment scanner with a double-buffered hex value and a refresh divider.
// Optional: define LEADING_ZERO_BLANK_EN to darken digits above the most significant non-zero digit.
module fa4_display_scanner #(
    parameter int DIGITS = 2,
    parameter int TICKS  = 500
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [4*DIGITS-1:0] disp_data,
    input  logic                disp_valid,
    output logic                disp_ready,
    input  logic                blank,
    output logic [DIGITS-1:0]   digit_sel,
    output logic [7:0]          segments,
    output logic                frame_done
);
    localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [TW-1:0]         r_tick;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_shadow;
    logic [4*DIGITS-1:0]   r_pend;
    logic                  r_pend_full;
    logic [DIGITS-1:0]     r_digit_sel;
    logic [7:0]            r_segments;
    logic                  r_frame_done;

    logic                  w_step;
    logic                  w_boundary;
    logic                  w_xfer;
    logic [3:0]            w_nib;
    logic [DIGITS-1:0]     w_sel;
    logic                  w_dark;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign w_step     = (r_tick == TW'(TICKS - 1));
    assign w_boundary = w_step && (r_idx == IW'(DIGITS - 1));
    assign w_xfer     = disp_valid && !r_pend_full;
    assign disp_ready = !r_pend_full;

    always_comb begin
        w_nib = 4'h0;
        w_sel = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib    = r_shadow[4*i +: 4];
                w_sel[i] = 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [IW-1:0] w_msd;
    always_comb begin
        w_msd = '0;
        for (int i = 0; i < DIGITS; i++)
            if (r_shadow[4*i +: 4] != 4'h0) w_msd = IW'(i);
    end
    assign w_dark = blank || (r_idx > w_msd);
`else
    assign w_dark = blank;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tick       <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
            r_digit_sel  <= '0;
            r_segments   <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            if (w_step) begin
                r_tick <= '0;
                r_idx  <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
            end else begin
                r_tick <= r_tick + TW'(1);
            end

            // Pending can only be filled while empty and drained while full, so these never collide.
            if (w_xfer) begin
                r_pend      <= disp_data;
                r_pend_full <= 1'b1;
            end else if (w_boundary && r_pend_full) begin
                r_shadow    <= r_pend;
                r_pend_full <= 1'b0;
            end

            r_frame_done <= w_boundary;
            r_digit_sel  <= blank ? '0 : w_sel;
            r_segments   <= w_dark ? 8'hFF : {1'b1, hex7(w_nib)};
        end
    end

    assign digit_sel  = r_digit_sel;
    assign segments   = r_segments;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_fa4_display_scanner.sv
// Randomized bench for fa4_display_scanner against a frame-arithmetic reference model.
module tb_fa4_display_scanner;
    localparam int DIGITS = 2;
    localparam int TICKS  = 4;
    localparam int FRAME  = DIGITS * TICKS;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic [4*DIGITS-1:0] disp_data = '0;
    logic                disp_valid = 1'b0;
    logic                disp_ready;
    logic                blank = 1'b0;
    logic [DIGITS-1:0]   digit_sel;
    logic [7:0]          segments;
    logic                frame_done;

    int total = 0;
    int bad = 0;

    fa4_display_scanner #(.DIGITS(DIGITS), .TICKS(TICKS)) dut (
        .clock(clock), .reset_n(reset_n), .disp_data(disp_data), .disp_valid(disp_valid),
        .disp_ready(disp_ready), .blank(blank), .digit_sel(digit_sel), .segments(segments),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return {1'b1, t[v]};
    endfunction

    // Model: position in scan derives from cycles since reset; double buffer as value+flag.
    int                  m_n;
    logic [4*DIGITS-1:0] m_shadow, m_pend;
    bit                  m_full;
    logic [DIGITS-1:0]   e_sel;
    logic [7:0]          e_seg;
    bit                  e_fd;

    task automatic mdl_reset();
        m_n = 0; m_shadow = '0; m_pend = '0; m_full = 0;
        e_sel = '0; e_seg = 8'hFF; e_fd = 0;
    endtask

    task automatic mdl_step();
        int  ph  = m_n % FRAME;
        int  idx = ph / TICKS;
        bit  bnd = (ph == FRAME - 1);
        bit  dark = blank;
`ifdef LEADING_ZERO_BLANK_EN
        int msd = 0;
        for (int i = 0; i < DIGITS; i++) if (m_shadow[4*i +: 4] != 0) msd = i;
        if (idx > msd) dark = 1;
`endif
        e_sel = blank ? '0 : DIGITS'(1 << idx);
        e_seg = dark ? 8'hFF : seg_of(m_shadow[4*idx +: 4]);
        e_fd  = bnd;
        if (disp_valid && !m_full) begin
            m_pend = disp_data; m_full = 1;
        end else if (bnd && m_full) begin
            m_shadow = m_pend; m_full = 0;
        end
        m_n++;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "digit_sel"}, 32'(digit_sel), 32'(e_sel));
        chk({pfx, "segments"}, 32'(segments), 32'(e_seg));
        chk({pfx, "frame_done"}, 32'(frame_done), 32'(e_fd));
        chk({pfx, "disp_ready"}, 32'(disp_ready), 32'(!m_full));
    endtask

    initial begin
        int blank_left = 0;
        int vprob = 50;
        mdl_reset();
        @(negedge clock);
        @(negedge clock);
        check_outputs("rst_");
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            check_outputs("run_");
            if (cyc == 900) begin
                #2 reset_n = 1'b0;
                #1;
                chk("async_rst_digit_sel", 32'(digit_sel), 32'(0));
                chk("async_rst_segments", 32'(segments), 32'hFF);
                chk("async_rst_frame_done", 32'(frame_done), 32'(0));
                chk("async_rst_ready", 32'(disp_ready), 32'(1));
                @(negedge clock);
                reset_n = 1'b1;
                mdl_reset();
                check_outputs("post_rst_");
            end
            if (cyc % 200 == 0) vprob = $urandom_range(5, 100);
            if (blank_left > 0) blank_left--;
            else if ($urandom_range(0, 39) == 0) blank_left = 10;
            blank      = (blank_left > 0);
            disp_valid = ($urandom_range(1, 100) <= vprob);
            if ($urandom_range(0, 1) == 0) disp_data = 8'($urandom);
            else disp_data = 8'($urandom_range(0, 15));
            mdl_step();
            @(negedge clock);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
